// File: rtl/dct_quant_pkg.sv
// dct_quant_pkg: shared types and constants for the dct_quant stage.
// Holds the FSM encoding, block framing constants and shift helpers.
package dct_quant_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   localparam int COEF_W = 14;
   localparam int BLK_SIZE = 64;
   localparam int DRAIN = 3;
   localparam logic [2:0] QS_MAX = 3'd4;

   // Coarser quantization toward the high-frequency corner of the block.
   function automatic logic [2:0] base_sh(input logic [5:0] k);
      logic [3:0] s;
      s = {1'b0, k[5:3]} + {1'b0, k[2:0]};
      return 3'(s >> 2);
   endfunction

   function automatic logic [2:0] clamp_qs(input logic [2:0] q);
      return (q > QS_MAX) ? QS_MAX : q;
   endfunction

endpackage

// File: rtl/dct_quant_lane.sv
// dct_quant_lane: three-stage quantize/dequantize pipeline for one coefficient.
// A two-bit tag travels with each coefficient for block framing.
module dct_quant_lane
   import dct_quant_pkg::*;
#(
   parameter int CW = COEF_W
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          kill,
   input  logic          in_valid,
   input  logic [CW-1:0] c,
   input  logic [2:0]    sh,
   input  logic [1:0]    tag_in,
   output logic          out_valid,
   output logic [CW-1:0] r,
   output logic          is_zero,
   output logic [1:0]    tag_out
);

   localparam int MW = CW + 1;
   localparam logic [MW-1:0] LIM_POS = MW'((1 << (CW - 1)) - 1);
   localparam logic [MW-1:0] LIM_NEG = MW'(1 << (CW - 1));

   logic          s1_v;
   logic [CW-1:0] s1_c;
   logic [2:0]    s1_sh;
   logic [1:0]    s1_tag;

   logic          s2_v;
   logic          s2_neg;
   logic [MW-1:0] s2_q;
   logic [2:0]    s2_sh;
   logic [1:0]    s2_tag;

   logic [MW-1:0] ext;
   logic [MW-1:0] mag;
   logic [MW-1:0] half;
   logic [MW-1:0] q_nxt;
   logic [MW-1:0] rr;
   logic [MW-1:0] lim;
   logic [MW-1:0] sat;
   logic [CW-1:0] r_nxt;

   always_comb begin
      ext   = {s1_c[CW-1], s1_c};
      mag   = s1_c[CW-1] ? (~ext + MW'(1)) : ext;
      half  = '0;
      if (s1_sh != 3'd0) half = MW'(1) << (s1_sh - 3'd1);
      q_nxt = (mag + half) >> s1_sh;
   end

   // Only -2^(CW-1) survives at full magnitude; +2^(CW-1) saturates.
   always_comb begin
      rr    = s2_q << s2_sh;
      lim   = s2_neg ? LIM_NEG : LIM_POS;
      sat   = (rr > lim) ? lim : rr;
      r_nxt = s2_neg ? CW'(~sat + MW'(1)) : CW'(sat);
   end

   always_ff @(posedge clk) begin
      if (!reset || kill) begin
         s1_v      <= 1'b0;
         s1_c      <= '0;
         s1_sh     <= '0;
         s1_tag    <= '0;
         s2_v      <= 1'b0;
         s2_neg    <= 1'b0;
         s2_q      <= '0;
         s2_sh     <= '0;
         s2_tag    <= '0;
         out_valid <= 1'b0;
         r         <= '0;
         is_zero   <= 1'b0;
         tag_out   <= '0;
      end else begin
         s1_v      <= in_valid;
         s1_c      <= c;
         s1_sh     <= sh;
         s1_tag    <= tag_in;
         s2_v      <= s1_v;
         s2_neg    <= s1_c[CW-1];
         s2_q      <= q_nxt;
         s2_sh     <= s1_sh;
         s2_tag    <= s1_tag;
         out_valid <= s2_v;
         r         <= s2_v ? r_nxt : '0;
         is_zero   <= s2_v && (s2_q == '0);
         tag_out   <= s2_v ? s2_tag : 2'b00;
      end
   end

endmodule

// File: rtl/dct_quant.sv
// dct_quant: block-framed power-of-two quantize/dequantize between dct and idct.
// Owns the block FSM, index counter, qshift latch, zero count and abort pulse.
module dct_quant
   import dct_quant_pkg::*;
#(
   parameter int BitWidth = 31,
   parameter int CW = COEF_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                din_valid,
   input  logic [CW-1:0]       din,
   input  logic [2:0]          qshift,
   output logic                done,
   output logic [BitWidth:0]   dout,
   output logic                block_end,
   output logic [6:0]          zero_cnt,
   output logic                err,
   output logic [1:0]          state_out
);

   state_t      state;
   logic [5:0]  k;
   logic [2:0]  qs;
   logic [1:0]  drain;
   logic        abort;
   logic [2:0]  qs_eff;
   logic [3:0]  sh_sum;
   logic [2:0]  sh;
   logic [1:0]  tag;

   logic          o_v;
   logic [CW-1:0] o_r;
   logic          o_zero;
   logic [1:0]    o_tag;

   logic [6:0]  acc;
   logic [6:0]  cnt_now;
   logic [6:0]  zq;

   assign abort  = (state == RUN) && !din_valid;
   assign qs_eff = (k == 6'd0) ? clamp_qs(qshift) : qs;
   assign sh_sum = {1'b0, base_sh(k)} + {1'b0, qs_eff};
   assign sh     = (sh_sum > 4'd7) ? 3'd7 : sh_sum[2:0];
   assign tag    = {k == 6'(BLK_SIZE - 1), k == 6'd0};

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         k     <= '0;
         qs    <= '0;
         drain <= '0;
         err   <= 1'b0;
      end else begin
         err <= abort;
         if (din_valid) begin
            k <= k + 6'd1;
            if (k == 6'd0) qs <= clamp_qs(qshift);
         end
         unique case (state)
            IDLE: begin
               if (din_valid) state <= RUN;
            end
            RUN: begin
               if (!din_valid) begin
                  state <= IDLE;
                  k     <= '0;
               end else if (k == 6'(BLK_SIZE - 1)) begin
                  state <= FLUSH;
                  drain <= '0;
               end
            end
            FLUSH: begin
               if (din_valid) state <= RUN;
               else if (drain == 2'(DRAIN - 1)) state <= IDLE;
               else drain <= drain + 2'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   dct_quant_lane #(
      .CW(CW)
   ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .kill     (abort),
      .in_valid (din_valid),
      .c        (din),
      .sh       (sh),
      .tag_in   (tag),
      .out_valid(o_v),
      .r        (o_r),
      .is_zero  (o_zero),
      .tag_out  (o_tag)
   );

   // Count on the output side so a killed partial block never reports.
   assign cnt_now = (o_tag[0] ? 7'd0 : acc) + {6'd0, o_zero};

   always_ff @(posedge clk) begin
      if (!reset) begin
         acc <= '0;
         zq  <= '0;
      end else if (o_v) begin
         acc <= cnt_now;
         if (o_tag[1]) zq <= cnt_now;
      end
   end

   assign done      = o_v;
   assign dout      = {{(BitWidth + 1 - CW){o_r[CW-1]}}, o_r};
   assign block_end = o_v && o_tag[1];
   assign zero_cnt  = block_end ? cnt_now : zq;
   assign state_out = state;

endmodule

// File: tb/tb_dct_quant.sv
// tb_dct_quant: randomized scoreboard bench for dct_quant.
// Expected outputs come from a plain-arithmetic model of the quantizer.
module tb_dct_quant;

   logic        clk = 1'b0;
   logic        reset;
   logic        din_valid;
   logic [13:0] din;
   logic [2:0]  qshift;
   logic        done;
   logic [31:0] dout;
   logic        block_end;
   logic [6:0]  zero_cnt;
   logic        err;
   logic [1:0]  state_out;

   always #5 clk = ~clk;

   dct_quant #(
      .BitWidth(31),
      .CW(14)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .din_valid(din_valid),
      .din      (din),
      .qshift   (qshift),
      .done     (done),
      .dout     (dout),
      .block_end(block_end),
      .zero_cnt (zero_cnt),
      .err      (err),
      .state_out(state_out)
   );

   typedef struct {
      logic [31:0] d;
      bit          last;
      int          zc;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   blk[64];
   int   first_drv = -1;
   int   rise_cyc = -1;
   int   run_len = 0;
   int   max_run = 0;
   int   be_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(string nm, logic [31:0] act,
                                 logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)",
                  nm, act, req, cyc);
      end
   endfunction

   // Reference: quantize magnitude with round-half-up, rescale, clamp.
   function automatic int ref_out(int c, int k, int qs, output bit z);
      int row, col, sh, m, q, r, v;
      row = k / 8;
      col = k % 8;
      sh = (row + col) / 4 + qs;
      if (sh > 7) sh = 7;
      m = (c < 0) ? -c : c;
      if (sh == 0) q = m;
      else q = (m + (1 << (sh - 1))) / (1 << sh);
      z = (q == 0);
      r = q * (1 << sh);
      v = (c < 0) ? -r : r;
      if (v > 8191) v = 8191;
      if (v < -8192) v = -8192;
      return v;
   endfunction

   function automatic int rnd_coef();
      if ($urandom_range(0, 2) == 0) return $urandom_range(0, 40) - 20;
      return $urandom_range(0, 16383) - 8192;
   endfunction

   task automatic fill_rand();
      for (int i = 0; i < 64; i++) blk[i] = rnd_coef();
   endtask

   task automatic send(input int qsh, input int n, input bit b2b_chk);
      int zc;
      int v;
      int mqs;
      bit z;
      zc = 0;
      mqs = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (b2b_chk) check("b2b_state_not_idle", 32'(state_out != 2'd0), 1);
         din_valid = 1'b1;
         din = 14'(blk[i]);
         if (i == 0) begin
            qshift = 3'(qsh);
            mqs = (qsh > 4) ? 4 : qsh;
            if (first_drv < 0) first_drv = cyc;
         end else begin
            qshift = 3'($urandom_range(0, 7));
         end
         v = ref_out(blk[i], i, mqs, z);
         zc += int'(z);
         exp_q.push_back('{d: 32'(v), last: (i == 63), zc: zc});
      end
   endtask

   task automatic drain();
      @(posedge clk);
      #1;
      din_valid = 1'b0;
      din = 14'($urandom);
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
      repeat (4) @(posedge clk);
      #1;
      check("drain_empty", 32'(exp_q.size()), 0);
   endtask

   task automatic check_zero(string tag);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_dout"}, dout, 0);
      check({tag, "_block_end"}, 32'(block_end), 0);
      check({tag, "_zero_cnt"}, 32'(zero_cnt), 0);
      check({tag, "_err"}, 32'(err), 0);
      check({tag, "_state"}, 32'(state_out), 0);
   endtask

   initial begin : monitor
      exp_t e;
      bit pdone;
      pdone = 1'b0;
      forever begin
         @(negedge clk);
         if (done) begin
            if (!pdone && rise_cyc < 0) rise_cyc = cyc;
            if (block_end) be_cnt++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_out: got dout=%0h, required no output",
                        dout);
            end else begin
               e = exp_q.pop_front();
               check("dout", dout, e.d);
               check("block_end", 32'(block_end), 32'(e.last));
               if (e.last) check("zero_cnt", 32'(zero_cnt), 32'(e.zc));
            end
            run_len++;
         end else begin
            if (block_end) begin
               miscompares++;
               $display("FAIL stray_block_end: got 1, required 0");
            end
            if (run_len > max_run) max_run = run_len;
            run_len = 0;
         end
         pdone = done;
      end
   end

   initial begin : stim
      reset = 1'b0;
      din_valid = 1'b0;
      din = '0;
      qshift = '0;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      reset = 1'b1;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 64; i++) blk[i] = 37;
      send(0, 64, 1'b0);
      drain();
      check("latency", 32'(rise_cyc - first_drv), 3);

      fill_rand();
      blk[63] = -8192;
      send(4, 64, 1'b0);
      fill_rand();
      blk[63] = 8191;
      send(4, 64, 1'b0);
      drain();

      for (int i = 0; i < 64; i++) blk[i] = 3;
      send(4, 64, 1'b0);
      drain();

      max_run = 0;
      be_cnt = 0;
      fill_rand();
      send($urandom_range(0, 7), 64, 1'b0);
      fill_rand();
      send($urandom_range(0, 7), 64, 1'b1);
      drain();
      check("b2b_done_run", 32'(max_run), 128);
      check("b2b_block_ends", 32'(be_cnt), 2);

      be_cnt = 0;
      fill_rand();
      send(2, 20, 1'b0);
      @(posedge clk);
      #1;
      din_valid = 1'b0;
      @(posedge clk);
      #1;
      check("abort_err", 32'(err), 1);
      check("abort_state", 32'(state_out), 0);
      exp_q.delete();
      @(posedge clk);
      #1;
      check("abort_err_pulse", 32'(err), 0);
      check("abort_done", 32'(done), 0);
      fill_rand();
      send(1, 64, 1'b0);
      drain();
      check("abort_block_ends", 32'(be_cnt), 1);

      fill_rand();
      send(3, 30, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      din = 14'($urandom);
      @(posedge clk);
      #1;
      reset = 1'b1;
      din_valid = 1'b0;
      check_zero("midreset");
      exp_q.delete();
      fill_rand();
      send(0, 64, 1'b0);
      drain();

      for (int b = 0; b < 5; b++) begin
         fill_rand();
         send($urandom_range(0, 7), 64, 1'b0);
         if ($urandom_range(0, 1) == 1) drain();
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
